// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Definitions shared by the I2C target and its bus front end:
//   - i2c_tgt_state_t : FSM states of i2c_target
//   - I2C_RW_*        : value of the R/W bit that follows the 7-bit address
//   - I2C_ACK/NACK    : SDA level during the acknowledge slot
// -----------------------------------------------------------------------------
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ADDR     = 3'd1,
        ADDR_ACK = 3'd2,
        WR_BYTE  = 3'd3,
        WR_ACK   = 3'd4,
        RD_BYTE  = 3'd5,
        RD_ACK   = 3'd6,
        IGNORE   = 3'd7
    } i2c_tgt_state_t;

    localparam logic I2C_RW_WRITE = 1'b0;
    localparam logic I2C_RW_READ  = 1'b1;
    localparam logic I2C_ACK      = 1'b0;
    localparam logic I2C_NACK     = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// -----------------------------------------------------------------------------
// i2c_bus_sync
// Brings the raw SCL/SDA pad signals into the clk domain and derives the
// bus events the target FSM needs.
//   clk, rst_n   : system clock, asynchronous active-low reset
//   i_scl, i_sda : raw pad levels
//   o_sda        : synchronised SDA level
//   o_scl_rise   : one-cycle pulse on a synchronised SCL rising edge
//   o_scl_fall   : one-cycle pulse on a synchronised SCL falling edge
//   o_start      : one-cycle pulse, SDA fell while SCL high
//   o_stop       : one-cycle pulse, SDA rose while SCL high
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_prev;
    logic                   r_sda_prev;
    logic                   w_scl;
    logic                   w_sda;

    // Reset to the idle-bus level (both lines high) so that leaving reset
    // never produces a spurious edge, START or STOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_prev <= w_scl;
            r_sda_prev <= w_sda;
        end
    end

    assign w_scl      = r_scl_sync[SYNC_STAGES-1];
    assign w_sda      = r_sda_sync[SYNC_STAGES-1];
    assign o_sda      = w_sda;
    assign o_scl_rise = w_scl & ~r_scl_prev;
    assign o_scl_fall = ~w_scl & r_scl_prev;
    assign o_start    = w_scl & r_sda_prev & ~w_sda;
    assign o_stop     = w_scl & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_target.sv
// -----------------------------------------------------------------------------
// i2c_target
// I2C target (slave) decoding START, 7-bit address, R/W, data and STOP from
// the bus, with an open-drain SDA output and no clock stretching.
//   clk, rst_n : system clock, asynchronous active-low reset
//   scl_in     : raw SCL from the pad
//   sda_in     : raw SDA from the pad
//   sda_pull   : 1 = pull SDA low, 0 = release (never driven high)
//   busy       : address-matched transfer in progress
//   rx_data    : last byte written by the master
//   rx_valid   : one-cycle strobe for rx_data
//   rx_first   : with rx_valid, marks the first data byte after a (re)START
//   rx_ready   : local logic can accept the byte; 0 makes the target NACK
//   tx_req     : one-cycle request for the next read byte
//   tx_data    : read byte, captured on the cycle after tx_req
//   dbg_state  : current FSM state
//
// Local interface handshakes: rx_valid is a push-only strobe (no
// backpressure on the strobe itself); rx_ready is sampled on the 8th data
// rise of each write byte and only decides ACK/NACK. tx_req is a one-cycle
// request; tx_data must be stable on the cycle following tx_req.
// -----------------------------------------------------------------------------
module i2c_target
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           scl_in,
    input  logic           sda_in,
    output logic           sda_pull,
    output logic           busy,
    output logic [7:0]     rx_data,
    output logic           rx_valid,
    output logic           rx_first,
    input  logic           rx_ready,
    output logic           tx_req,
    input  logic [7:0]     tx_data,
    output i2c_tgt_state_t dbg_state
);

    logic           w_sda;
    logic           w_scl_rise;
    logic           w_scl_fall;
    logic           w_start;
    logic           w_stop;
    logic [7:0]     w_rx_byte;

    i2c_tgt_state_t r_state;
    logic [2:0]     r_bit_cnt;
    logic [7:0]     r_shift;
    logic           r_rw;
    logic           r_busy;
    logic           r_sda_pull;
    logic [7:0]     r_rx_data;
    logic           r_rx_valid;
    logic           r_rx_first;
    logic           r_first_pend;   // next completed write byte is the first
    logic           r_rx_ready_s;   // rx_ready captured on the 8th rise
    logic           r_tx_req;
    logic           r_tx_load;      // cycle after tx_req: capture tx_data
    logic           r_byte_done;    // 8 bits in, waiting for the fall
    logic           r_rd_first;     // next fall drives the MSB, no shift

    i2c_bus_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_scl      (scl_in),
        .i_sda      (sda_in),
        .o_sda      (w_sda),
        .o_scl_rise (w_scl_rise),
        .o_scl_fall (w_scl_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    assign w_rx_byte = {r_shift[6:0], w_sda};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_rw         <= I2C_RW_WRITE;
            r_busy       <= 1'b0;
            r_sda_pull   <= 1'b0;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_rx_first   <= 1'b0;
            r_first_pend <= 1'b0;
            r_rx_ready_s <= 1'b0;
            r_tx_req     <= 1'b0;
            r_tx_load    <= 1'b0;
            r_byte_done  <= 1'b0;
            r_rd_first   <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_rx_first <= 1'b0;
            r_tx_req   <= 1'b0;
            r_tx_load  <= r_tx_req;
            if (r_tx_load) begin
                r_shift <= tx_data;
            end

            // Bus conditions override any SCL edge seen in the same cycle.
            if (w_start) begin
                r_state      <= ADDR;
                r_bit_cnt    <= 3'd7;
                r_sda_pull   <= 1'b0;
                r_shift      <= 8'h00;
                r_byte_done  <= 1'b0;
                r_first_pend <= 1'b1;
                r_rd_first   <= 1'b0;
            end else if (w_stop) begin
                r_state     <= IDLE;
                r_sda_pull  <= 1'b0;
                r_busy      <= 1'b0;
                r_byte_done <= 1'b0;
            end else begin
                case (r_state)
                    ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            if (r_bit_cnt == 3'd0) begin
                                if (w_rx_byte[7:1] == DEV_ADDR) begin
                                    r_rw        <= w_rx_byte[0];
                                    r_busy      <= 1'b1;
                                    r_byte_done <= 1'b1;
                                end else begin
                                    r_state <= IGNORE;
                                    r_busy  <= 1'b0;
                                end
                            end
                        end else if (w_scl_fall && r_byte_done) begin
                            r_byte_done <= 1'b0;
                            r_state     <= ADDR_ACK;
                            r_sda_pull  <= 1'b1;
                            r_tx_req    <= (r_rw == I2C_RW_READ);
                        end
                    end

                    ADDR_ACK: begin
                        if (w_scl_fall) begin
                            r_bit_cnt <= 3'd7;
                            if (r_rw == I2C_RW_READ) begin
                                r_state    <= RD_BYTE;
                                r_sda_pull <= ~r_shift[7];
                            end else begin
                                r_state    <= WR_BYTE;
                                r_sda_pull <= 1'b0;
                            end
                        end
                    end

                    WR_BYTE: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_rx_byte;
                            r_bit_cnt <= r_bit_cnt - 3'd1;
                            if (r_bit_cnt == 3'd0) begin
                                r_rx_data    <= w_rx_byte;
                                r_rx_valid   <= 1'b1;
                                r_rx_first   <= r_first_pend;
                                r_first_pend <= 1'b0;
                                r_rx_ready_s <= rx_ready;
                                r_byte_done  <= 1'b1;
                            end
                        end else if (w_scl_fall && r_byte_done) begin
                            r_byte_done <= 1'b0;
                            r_state     <= WR_ACK;
                            r_sda_pull  <= r_rx_ready_s;
                        end
                    end

                    WR_ACK: begin
                        if (w_scl_fall) begin
                            r_sda_pull <= 1'b0;
                            if (!r_rx_ready_s) begin
                                r_state <= IGNORE;
                                r_busy  <= 1'b0;
                            end else begin
                                r_state   <= WR_BYTE;
                                r_bit_cnt <= 3'd7;
                            end
                        end
                    end

                    RD_BYTE: begin
                        // Falls are counted here: each one moves to the
                        // next bit; the fall after bit 0 releases SDA.
                        if (w_scl_fall) begin
                            if (r_rd_first) begin
                                r_rd_first <= 1'b0;
                                r_sda_pull <= ~r_shift[7];
                            end else if (r_bit_cnt == 3'd0) begin
                                r_sda_pull <= 1'b0;
                                r_bit_cnt  <= 3'd7;
                                r_state    <= RD_ACK;
                            end else begin
                                r_shift    <= {r_shift[6:0], 1'b0};
                                r_sda_pull <= ~r_shift[6];
                                r_bit_cnt  <= r_bit_cnt - 3'd1;
                            end
                        end
                    end

                    RD_ACK: begin
                        if (w_scl_rise) begin
                            if (w_sda == I2C_ACK) begin
                                r_tx_req   <= 1'b1;
                                r_rd_first <= 1'b1;
                                r_state    <= RD_BYTE;
                            end else begin
                                r_state <= IGNORE;
                                r_busy  <= 1'b0;
                            end
                        end
                    end

                    default: begin
                        // IDLE and IGNORE wait for START/STOP only.
                    end
                endcase
            end
        end
    end

    assign sda_pull  = r_sda_pull;
    assign busy      = r_busy;
    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign rx_first  = r_rx_first;
    assign tx_req    = r_tx_req;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_i2c_target.sv
module tb_i2c_target;
    import i2c_pkg::*;

    localparam int Q = 8;   // clk cycles per quarter SCL period

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- bus model ----------------
    logic           m_scl = 1'b1;
    logic           m_sda = 1'b1;
    logic           rx_ready = 1'b1;
    logic [7:0]     tx_data = 8'hFF;
    logic           sda_pull;
    logic           busy;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           rx_first;
    logic           tx_req;
    i2c_tgt_state_t dbg_state;
    wire            w_sda_bus = m_sda & ~sda_pull;

    i2c_target #(
        .DEV_ADDR    (7'h42),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_in    (m_scl),
        .sda_in    (w_sda_bus),
        .sda_pull  (sda_pull),
        .busy      (busy),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_first  (rx_first),
        .rx_ready  (rx_ready),
        .tx_req    (tx_req),
        .tx_data   (tx_data),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int         n_vec = 0;
    int         n_fail = 0;
    int         n_rx = 0;
    int         n_txreq = 0;
    logic       pull_seen = 1'b0;
    logic [8:0] exp_q[$];   // {rx_first, rx_data}
    logic [7:0] tx_q[$];    // bytes handed out on tx_req

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected queue whenever the DUT strobes a byte out,
    // and serves read bytes on tx_req.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sda_pull) pull_seen = 1'b1;
                if (rx_valid) begin
                    n_rx++;
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_fail++;
                        $display("FAIL rx_unexpected: got %0h expected none", {rx_first, rx_data});
                    end else begin
                        check("rx_byte", {23'd0, rx_first, rx_data}, {23'd0, exp_q.pop_front()});
                    end
                end
                if (tx_req) begin
                    n_txreq++;
                    tx_data = (tx_q.size() != 0) ? tx_q.pop_front() : 8'hFF;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        m_sda = b;    wait_clk(Q);
        m_scl = 1'b1; wait_clk(2 * Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        b = w_sda_bus; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string name);
        logic a;
        for (int i = 7; i >= 0; i--) write_bit(d[i]);
        read_bit(a);
        check(name, {31'd0, a}, {31'd0, exp_ack});
    endtask

    task automatic read_byte(input logic [7:0] exp, input logic nack, input string name);
        logic [7:0] got;
        logic b;
        got = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            got[i] = b;
        end
        check(name, {24'd0, got}, {24'd0, exp});
        write_bit(nack);
    endtask

    // ---------------- stimulus ----------------
    int rx0;
    logic tmp_b;

    initial begin
        // Reset values
        wait_clk(3);
        check("rst_sda_pull", {31'd0, sda_pull}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_rx_first", {31'd0, rx_first}, 32'd0);
        check("rst_tx_req", {31'd0, tx_req}, 32'd0);
        check("rst_state", {29'd0, dbg_state}, {29'd0, IDLE});
        rst_n = 1'b1;
        wait_clk(10);

        // 1: write A5, 3C to 0x42
        rx_ready = 1'b1;
        i2c_start();
        write_byte(8'h84, I2C_ACK, "t1_addr_ack");
        check("t1_busy", {31'd0, busy}, 32'd1);
        exp_q.push_back({1'b1, 8'hA5});
        write_byte(8'hA5, I2C_ACK, "t1_d0_ack");
        exp_q.push_back({1'b0, 8'h3C});
        write_byte(8'h3C, I2C_ACK, "t1_d1_ack");
        check("t1_busy_before_stop", {31'd0, busy}, 32'd1);
        i2c_stop();
        wait_clk(Q);
        check("t1_busy_after_stop", {31'd0, busy}, 32'd0);
        check("t1_rx_count", n_rx, 32'd2);

        // 2: address 0x43 is not ours
        rx0 = n_rx;
        pull_seen = 1'b0;
        i2c_start();
        write_byte(8'h86, I2C_NACK, "t2_addr_nack");
        write_byte(8'h55, I2C_NACK, "t2_data_nack");
        check("t2_state", {29'd0, dbg_state}, {29'd0, IGNORE});
        check("t2_busy", {31'd0, busy}, 32'd0);
        i2c_stop();
        wait_clk(Q);
        check("t2_pull_seen", {31'd0, pull_seen}, 32'd0);
        check("t2_no_rx", n_rx - rx0, 32'd0);
        check("t2_state_idle", {29'd0, dbg_state}, {29'd0, IDLE});

        // 3: read C3 (ACK), 5A (NACK)
        n_txreq = 0;
        tx_q.push_back(8'hC3);
        tx_q.push_back(8'h5A);
        i2c_start();
        write_byte(8'h85, I2C_ACK, "t3_addr_ack");
        read_byte(8'hC3, I2C_ACK, "t3_rd0");
        read_byte(8'h5A, I2C_NACK, "t3_rd1");
        wait_clk(Q);
        check("t3_txreq_count", n_txreq, 32'd2);
        check("t3_sda_released", {31'd0, sda_pull}, 32'd0);
        check("t3_state", {29'd0, dbg_state}, {29'd0, IGNORE});
        check("t3_busy", {31'd0, busy}, 32'd0);
        i2c_stop();

        // 4: data NACK when rx_ready=0
        rx_ready = 1'b0;
        i2c_start();
        write_byte(8'h84, I2C_ACK, "t4_addr_ack");
        exp_q.push_back({1'b1, 8'h11});
        write_byte(8'h11, I2C_NACK, "t4_data_nack");
        check("t4_state", {29'd0, dbg_state}, {29'd0, IGNORE});
        check("t4_busy", {31'd0, busy}, 32'd0);
        i2c_stop();
        rx_ready = 1'b1;

        // 5: partial write, repeated START, read
        rx0 = n_rx;
        n_txreq = 0;
        tx_q.push_back(8'h96);
        i2c_start();
        write_byte(8'h84, I2C_ACK, "t5_addr_w_ack");
        for (int i = 0; i < 4; i++) write_bit(1'b1);
        check("t5_state_wr", {29'd0, dbg_state}, {29'd0, WR_BYTE});
        i2c_start();
        write_byte(8'h85, I2C_ACK, "t5_addr_r_ack");
        read_byte(8'h96, I2C_NACK, "t5_rd");
        i2c_stop();
        wait_clk(Q);
        check("t5_no_rx", n_rx - rx0, 32'd0);
        check("t5_txreq_count", n_txreq, 32'd1);

        // 6: async reset mid-read while pulling SDA
        tx_q.push_back(8'h00);
        i2c_start();
        write_byte(8'h85, I2C_ACK, "t6_addr_ack");
        read_bit(tmp_b);
        read_bit(tmp_b);
        check("t6_pull_before_rst", {31'd0, sda_pull}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_pull_async", {31'd0, sda_pull}, 32'd0);
        check("t6_busy_async", {31'd0, busy}, 32'd0);
        wait_clk(2);
        m_scl = 1'b1;
        m_sda = 1'b1;
        wait_clk(4);
        rst_n = 1'b1;
        wait_clk(4);
        check("t6_state_idle", {29'd0, dbg_state}, {29'd0, IDLE});
        tx_q.delete();
        i2c_start();
        write_byte(8'h84, I2C_ACK, "t6_addr_ack2");
        exp_q.push_back({1'b1, 8'h7E});
        write_byte(8'h7E, I2C_ACK, "t6_data_ack");
        i2c_stop();
        wait_clk(2 * Q);

        check("exp_q_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    // Watchdog
    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Clock-domain I2C target (slave) that sits on the bus directly downstream of `i2c_master`.
- Consumes the master's `scl`/`sda` and decodes START, address, R/W, data and STOP.
- Write bytes go to local logic through a strobe interface. Read bytes are fetched through a request/data interface.
- Drives SDA open-drain only: it pulls low or releases, and never drives high.

Parameters:
- `DEV_ADDR`, `7'h42`, 7-bit address this target responds to.
- `SYNC_STAGES`, `2`, synchroniser depth on `scl_in`/`sda_in` (minimum 2).

Ports:
- `clk  input  1` — system clock; all logic on the rising edge.
- `rst_n  input  1` — asynchronous, active-low reset.
- `scl_in  input  1` — raw SCL from the pad.
- `sda_in  input  1` — raw SDA from the pad.
- `sda_pull  output  1` — 1 = pad pulls SDA low; 0 = released (pad logic drives `sda = sda_pull ? 0 : 'z`).
- `busy  output  1` — high from an address-matched START until STOP or NACK release.
- `rx_data  output  8` — last byte written by the master.
- `rx_valid  output  1` — one-cycle strobe; `rx_data` is valid on this cycle.
- `rx_first  output  1` — qualifies `rx_valid`; marks the first data byte after (re)START.
- `rx_ready  input  1` — sampled at the 8th data bit; 0 causes a NACK.
- `tx_req  output  1` — one-cycle strobe requesting the next read byte.
- `tx_data  input  8` — read byte; must be valid the cycle after `tx_req` (captured then).

Behaviour:

Reset and synchronisation:
- Reset values: `sda_pull=0`, `busy=0`, `rx_data=0`, `rx_valid=0`, `rx_first=0`, `tx_req=0`, state IDLE, bit counter 0.
- Inputs pass through `SYNC_STAGES` flops, plus one history flop for edge detection.
- `scl_rise`/`scl_fall` are one-cycle pulses from the synchronised SCL.

START/STOP detection (checked every cycle, in any state):
- START: synchronised SDA falls while synchronised SCL is high.
- STOP: synchronised SDA rises while SCL is high.
- START always forces state ADDR, bit counter 7, `sda_pull=0`, and clears shift register; repeated START is handled identically.
- STOP forces IDLE, `sda_pull=0`, `busy=0`.
- Priority: START/STOP > SCL edge handling in the same cycle.

Bit timing:
- Bits are sampled on `scl_rise`.
- `sda_pull` changes only on `scl_fall` (+1 cycle register latency).

States:
- IDLE: ignores SCL edges.
- ADDR:
  - Shift 8 bits MSB first (A6..A0, R/W).
  - On the 8th `scl_rise`:
    - Address match: latch R/W, set `busy=1`.
    - Mismatch: go to IGNORE.
  - On the following `scl_fall` → ADDR_ACK with `sda_pull=1`.
  - If R/W=1, pulse `tx_req` on that same `scl_fall` cycle; load the shifter from `tx_data` on the next cycle.
- ADDR_ACK: on `scl_fall`, `sda_pull=0`; go to WR_BYTE (W) or RD_BYTE (R).
  - On entry to RD_BYTE on that same fall, `sda_pull = ~shift[7]`.
- WR_BYTE:
  - 8 `scl_rise` samples.
  - On the 8th, `rx_data` updates and `rx_valid` pulses the next cycle; `rx_first=1` only for the first byte since START.
  - `rx_ready` is sampled on the 8th rise.
  - Next `scl_fall` → WR_ACK with `sda_pull = rx_ready`.
- WR_ACK: on `scl_fall`, `sda_pull=0`.
  - If NACKed → IGNORE, `busy=0`.
  - Otherwise → WR_BYTE.
- RD_BYTE:
  - On each `scl_fall` shift left and drive `sda_pull = ~next bit`.
  - After the 8th bit's fall, release SDA → RD_ACK.
- RD_ACK:
  - On `scl_rise`, sample master ACK.
  - SDA=0 → pulse `tx_req`, load `tx_data` next cycle, go to RD_BYTE; MSB is driven on the next `scl_fall`.
  - SDA=1 (NACK) → IGNORE, `busy=0`.
- IGNORE: SDA released; waits for START or STOP.

Widths and protocol rules:
- Bit counter is 3 bits and wraps 0→7 between bytes.
- No clock stretching: SCL is never driven.

Decomposition:
- Shared package `i2c_pkg`: `i2c_tgt_state_t` enum (IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE), `I2C_RW_WRITE=0`, `I2C_RW_READ=1`, `I2C_ACK=0`, `I2C_NACK=1`.
- One sub-module `i2c_bus_sync`: synchronisers, SCL edge pulses, START/STOP pulses.
- FSM and shifter stay in `i2c_target`.

Test Plan:
1. Bus-model write to `7'h42`, data `8'hA5`, `8'h3C`, `rx_ready=1`:
   - ACK on the address slot and both data slots.
   - `rx_valid` pulses twice with `A5` (`rx_first=1`) then `3C` (`rx_first=0`).
   - `busy` falls on STOP.
2. Address `7'h43` write: `sda_pull` stays 0 for the whole transfer, no `rx_valid`, `busy=0`, IDLE after STOP.
3. Read from `7'h42`, `tx_data` returns `8'hC3`, then `8'h5A`:
   - Master ACKs the first byte and NACKs the second.
   - Bus sees `C3` then `5A`.
   - Exactly 2 `tx_req` pulses.
   - SDA is released after the NACK.
4. Write `8'h11` with `rx_ready=0`: NACK on the data slot, `rx_valid` still pulses with `11`, state IGNORE, `busy=0`.
5. Write address + 4 data bits, then repeated START with a read of `7'h42`: no `rx_valid`, correct read of `tx_data`.
6. Assert `rst_n=0` mid-read while `sda_pull=1`: `sda_pull` drops to 0 asynchronously; after release, the next START is decoded normally.
